reg_file_sb: RTL and testbench

Parametrised, scoreboarded successor of the core register file. Provides a configurable number of read and write ports, a hard-wired zero at address 0, and per-register pending bits for issue-stage hazard detection. A post-reset init sequencer zeroes the whole array. It sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/reg_file_sb.sv | 121 ++++++++++++
 tb/tb_reg_file_sb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with zero register, pending scoreboard and init sequencer
// Optional same-cycle write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 6,
    parameter int RD_PORTS = 3,
    parameter int WR_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         init_busy,
    input  logic [WR_PORTS-1:0]          wr_ena,
    input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
    input  logic [WR_PORTS*XLEN-1:0]     wr_data,
    input  logic [RD_PORTS-1:0]          rd_ena,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*XLEN-1:0]     rd_data,
    output logic [RD_PORTS-1:0]          rd_pend,
    input  logic                         rsv_ena,
    input  logic [ADDR_W-1:0]            rsv_addr
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [NREG-1:0]     r_pend;
    logic                r_init_busy;
    logic [XLEN-1:0]     r_mem [1:NREG-1];

    logic [WR_PORTS-1:0] w_wr_eff;
    logic                w_rsv_eff;
    logic [NREG-1:0]     w_pend_nxt;
    logic [ADDR_W-1:0]   w_rd_a;

    assign init_busy = r_init_busy;

    // Writes and reservations only take effect once the array has been zeroed.
    always_comb begin
        w_wr_eff  = '0;
        w_rsv_eff = rsv_ena && (rsv_addr != '0) && (r_state == ST_READY);
        for (int i = 0; i < WR_PORTS; i++) begin
            w_wr_eff[i] = wr_ena[i] && (wr_addr[i*ADDR_W +: ADDR_W] != '0) && (r_state == ST_READY);
        end
    end

    // Clears first, then the reservation, so a same-cycle reserve beats the write.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < WR_PORTS; i++) begin
            if (w_wr_eff[i]) begin
                w_pend_nxt[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (w_rsv_eff) begin
            w_pend_nxt[rsv_addr] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= ADDR_W'(1);
            r_pend      <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == LAST_ADDR) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    r_pend <= w_pend_nxt;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Array has no reset; later ports in the loop override earlier ones on a collision.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (w_wr_eff[i]) begin
                    r_mem[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        w_rd_a  = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            w_rd_a = rd_addr[p*ADDR_W +: ADDR_W];
            if ((r_state == ST_READY) && rd_ena[p] && (w_rd_a != '0)) begin
                rd_data[p*XLEN +: XLEN] = r_mem[w_rd_a];
                rd_pend[p]              = r_pend[w_rd_a];
`ifdef REG_FILE_BYPASS_EN
                for (int i = 0; i < WR_PORTS; i++) begin
                    if (w_wr_eff[i] && (wr_addr[i*ADDR_W +: ADDR_W] == w_rd_a)) begin
                        rd_data[p*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
                        rd_pend[p]              = w_rsv_eff && (rsv_addr == w_rd_a);
                    end
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
module tb_reg_file_sb;
    localparam int XLEN = 32;
    localparam int AW   = 6;
    localparam int RDP  = 3;
    localparam int WRP  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                init_busy;
    logic [WRP-1:0]      wr_ena;
    logic [WRP*AW-1:0]   wr_addr;
    logic [WRP*XLEN-1:0] wr_data;
    logic [RDP-1:0]      rd_ena;
    logic [RDP*AW-1:0]   rd_addr;
    logic [RDP*XLEN-1:0] rd_data;
    logic [RDP-1:0]      rd_pend;
    logic                rsv_ena;
    logic [AW-1:0]       rsv_addr;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_sb #(.XLEN(XLEN), .ADDR_W(AW), .RD_PORTS(RDP), .WR_PORTS(WRP)) dut (
        .clk(clk), .reset(reset), .init_busy(init_busy),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_ena(rd_ena), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .rsv_ena(rsv_ena), .rsv_addr(rsv_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rdat(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic idle();
        wr_ena = '0; wr_addr = '0; wr_data = '0;
        rd_ena = '0; rd_addr = '0;
        rsv_ena = 1'b0; rsv_addr = '0;
    endtask

    task automatic wr(input int port, input int addr, input logic [XLEN-1:0] data);
        wr_ena[port]               = 1'b1;
        wr_addr[port*AW +: AW]     = AW'(addr);
        wr_data[port*XLEN +: XLEN] = data;
    endtask

    task automatic rd(input int port, input int addr);
        rd_ena[port]           = 1'b1;
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic rsv(input int addr);
        rsv_ena  = 1'b1;
        rsv_addr = AW'(addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for 3 cycles, then counts cycles until init_busy drops.
    task automatic run_init(input string tag);
        int cyc;
        reset = 1'b1;
        repeat (3) tick();
        check({tag, "_busy_in_reset"}, 64'(init_busy), 64'd1);
        reset = 1'b0;
        cyc = 0;
        while (init_busy && cyc < 200) begin
            idle();
            if (cyc == 0) begin
                rd(0, 63);
                #1;
                check({tag, "_rd_during_init"}, 64'(rdat(0)), 64'd0);
                check({tag, "_pend_during_init"}, 64'(rd_pend[0]), 64'd0);
            end
            if (cyc == 60) begin
                wr(0, 1, 32'h00000BAD);
                rsv(2);
            end
            tick();
            cyc++;
        end
        idle();
        check({tag, "_init_cycles"}, 64'(cyc), 64'd63);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        run_init("init1");

        wr(0, 1, 32'h11111111);
        wr(1, 63, 32'h63636363);
        tick();
        idle();
        wr(0, 33, 32'h33333333);
        tick();
        idle();
        rd(0, 63);
        rd(1, 33);
        #1;
        check("garbage63", 64'(rdat(0)), 64'h63636363);
        check("garbage33", 64'(rdat(1)), 64'h33333333);

        run_init("init2");
        for (int a = 0; a < 64; a++) begin
            idle();
            rd(a % 3, a);
            #1;
            check($sformatf("zero_a%0d", a), 64'(rdat(a % 3)), 64'd0);
        end
        idle();
        rd(0, 2);
        #1;
        check("rsv_ignored_in_init", 64'(rd_pend[0]), 64'd0);

        idle();
        wr(0, 5, 32'hDEADBEEF);
        wr(1, 0, 32'h12345678);
        tick();
        idle();
        rd(0, 5);
        rd(1, 0);
        rd_addr[2*AW +: AW] = AW'(5);
        #1;
        check("wr_a5", 64'(rdat(0)), 64'hDEADBEEF);
        check("rd_a0", 64'(rdat(1)), 64'd0);
        check("rd_disabled", 64'(rdat(2)), 64'd0);

        idle();
        wr(0, 7, 32'h1111);
        wr(1, 7, 32'h2222);
        rd(0, 7);
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("conflict_bypass", 64'(rdat(0)), 64'h2222);
`else
        check("conflict_old", 64'(rdat(0)), 64'd0);
`endif
        tick();
        idle();
        rd(0, 7);
        #1;
        check("conflict_a7", 64'(rdat(0)), 64'h2222);

        idle();
        rsv(9);
        rd(0, 9);
        #1;
        check("rsv_same_cycle", 64'(rd_pend[0]), 64'd0);
        tick();
        idle();
        rd(0, 9);
        #1;
        check("rsv_pend", 64'(rd_pend[0]), 64'd1);
        wr(0, 9, 32'h0000AAAA);
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("wr_clear_bypass", 64'(rd_pend[0]), 64'd0);
`else
        check("wr_clear_old", 64'(rd_pend[0]), 64'd1);
`endif
        tick();
        idle();
        rd(0, 9);
        #1;
        check("wr_cleared", 64'(rd_pend[0]), 64'd0);
        check("wr_a9", 64'(rdat(0)), 64'hAAAA);
        rsv(9);
        wr(1, 9, 32'h0000BBBB);
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("rsvwr_bp_pend", 64'(rd_pend[0]), 64'd1);
        check("rsvwr_bp_data", 64'(rdat(0)), 64'hBBBB);
`else
        check("rsvwr_old_pend", 64'(rd_pend[0]), 64'd0);
        check("rsvwr_old_data", 64'(rdat(0)), 64'hAAAA);
`endif
        tick();
        idle();
        rd(0, 9);
        #1;
        check("rsvwr_pend", 64'(rd_pend[0]), 64'd1);
        check("rsvwr_data", 64'(rdat(0)), 64'hBBBB);

        idle();
        wr(0, 3, 32'h00000033);
        tick();
        idle();
        wr(0, 3, 32'hCAFEF00D);
        rd(1, 3);
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("bypass_data", 64'(rdat(1)), 64'hCAFEF00D);
`else
        check("nobypass_data", 64'(rdat(1)), 64'h33);
`endif
        check("bypass_pend", 64'(rd_pend[1]), 64'd0);
        tick();
        idle();
        rd(1, 3);
        #1;
        check("after_bypass", 64'(rdat(1)), 64'hCAFEF00D);

        idle();
        rsv(4);
        wr(0, 10, 32'h10101010);
        tick();
        idle();
        rd(0, 4);
        rd(1, 10);
        #1;
        check("pre_rst_pend4", 64'(rd_pend[0]), 64'd1);
        check("pre_rst_a10", 64'(rdat(1)), 64'h10101010);
        #2;
        reset = 1'b1;
        #1;
        check("async_pend_clr", 64'(rd_pend[0]), 64'd0);
        check("async_busy", 64'(init_busy), 64'd1);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("mid_init_busy", 64'(init_busy), 64'd1);
        run_init("init3");
        idle();
        rd(0, 4);
        rd(1, 10);
        #1;
        check("post_rst_pend4", 64'(rd_pend[0]), 64'd0);
        check("post_rst_a10", 64'(rdat(1)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
